// File: rtl/dff_pipe_async_reset.sv
`default_nettype none
// ============================================================================
// Module : dff_pipe_async_reset
// Brief  : DEPTH-stage valid/ready register pipeline, async active-low reset,
//          sync flush; optional occupancy counter when DFF_PIPE_OCCUPANCY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module dff_pipe_async_reset #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DFF_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [WIDTH-1:0] r_data      [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] w_src_data  [DEPTH];
  logic [DEPTH-1:0] w_src_valid;
  logic [DEPTH:0]   w_ready;

  // A stage can accept when it is a bubble or everything downstream moves.
  always_comb begin
    w_ready        = '0;
    w_ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_ready[i] = !r_valid[i] || w_ready[i+1];
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_src
      if (i == 0) begin : g_head
        assign w_src_data[i]  = data;
        assign w_src_valid[i] = in_valid;
      end else begin : g_body
        assign w_src_data[i]  = r_data[i-1];
        assign w_src_valid[i] = r_valid[i-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= w_src_valid[i];
          // bubbles keep stale data to avoid needless register toggling
          if (w_src_valid[i]) begin
            r_data[i] <= w_src_data[i];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0] && !flush;
  assign q         = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
  localparam int c_OCC_W = $clog2(DEPTH + 1);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

  logic [c_OCC_W-1:0] r_occupancy;
  logic               w_in_xfer;
  logic               w_out_xfer;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occupancy <= '0;
    end else if (flush) begin
      r_occupancy <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occupancy <= r_occupancy + c_OCC_ONE;
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occupancy <= r_occupancy - c_OCC_ONE;
    end
  end

  assign occupancy = r_occupancy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_async_reset.sv
`default_nettype none
// ============================================================================
// Module : tb_dff_pipe_async_reset
// Brief  : self-checking bench: directed vector table, reset/flush sequences,
//          random traffic against queue scoreboards (DEPTH=3 and DEPTH=1).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_async_reset;

  localparam logic [7:0] RV_MAIN  = 8'hA5;
  localparam logic [7:0] RV_SMALL = 8'h3C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  logic       ir3, ov3, ir1, ov1;
  logic [7:0] q3, q1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef DFF_PIPE_OCCUPANCY_EN
  logic [1:0] occ3;
  logic [0:0] occ1;
  logic [2:0] occ4;
  logic       ir4, ov4;
  logic [7:0] q4;
`endif

  dff_pipe_async_reset #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(RV_MAIN)) u_main (
    .clk(clk), .reset(reset), .data(data), .in_valid(in_valid), .in_ready(ir3),
    .flush(flush), .q(q3), .out_valid(ov3), .out_ready(out_ready)
`ifdef DFF_PIPE_OCCUPANCY_EN
    , .occupancy(occ3)
`endif
  );

  dff_pipe_async_reset #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(RV_SMALL)) u_small (
    .clk(clk), .reset(reset), .data(data), .in_valid(in_valid), .in_ready(ir1),
    .flush(flush), .q(q1), .out_valid(ov1), .out_ready(out_ready)
`ifdef DFF_PIPE_OCCUPANCY_EN
    , .occupancy(occ1)
`endif
  );

`ifdef DFF_PIPE_OCCUPANCY_EN
  dff_pipe_async_reset #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_occ (
    .clk(clk), .reset(reset), .data(data), .in_valid(in_valid), .in_ready(ir4),
    .flush(flush), .q(q4), .out_valid(ov4), .out_ready(out_ready),
    .occupancy(occ4)
  );
`endif

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_q;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] sb3[$];
  logic [7:0] sb1[$];

  function automatic void add(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic fl, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_q);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_q = e_q;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    data      = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Reference: words leave in acceptance order; a pipe never holds more than DEPTH.
  task automatic score();
    if (ov3 && out_ready) begin
      if (sb3.size() == 0) begin
        total++; bad++;
        $display("FAIL main_spurious: actual=%0h required=none", q3);
      end else begin
        chk("main_order", q3, sb3.pop_front());
      end
    end
    if (in_valid && ir3) sb3.push_back(data);
    chk("main_fill", (sb3.size() <= 3), 1'b1);

    if (ov1 && out_ready) begin
      if (sb1.size() == 0) begin
        total++; bad++;
        $display("FAIL small_spurious: actual=%0h required=none", q1);
      end else begin
        chk("small_order", q1, sb1.pop_front());
      end
    end
    if (in_valid && ir1) sb1.push_back(data);
    chk("small_fill", (sb1.size() <= 1), 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov", ov3, 1'b0);
    chk("rst_q", q3, RV_MAIN);
    chk("rst_ir", ir3, 1'b1);
    chk("rst_q_small", q1, RV_SMALL);
`ifdef DFF_PIPE_OCCUPANCY_EN
    chk("rst_occ", occ3, 2'd0);
`endif
    reset = 1'b1;

    // latency/throughput, then stall/backpressure, then flush of a full pipe
    add(1, 8'h11, 1, 0, 1, 0, RV_MAIN);
    add(1, 8'h22, 1, 0, 1, 0, RV_MAIN);
    add(1, 8'h33, 1, 0, 1, 0, RV_MAIN);
    add(0, 8'h00, 1, 0, 1, 1, 8'h11);
    add(0, 8'h00, 1, 0, 1, 1, 8'h22);
    add(0, 8'h00, 1, 0, 1, 1, 8'h33);
    add(0, 8'h00, 1, 0, 1, 0, 8'h33);
    add(1, 8'h41, 0, 0, 1, 0, 8'h33);
    add(1, 8'h42, 0, 0, 1, 0, 8'h33);
    add(1, 8'h43, 0, 0, 1, 0, 8'h33);
    add(1, 8'h44, 0, 0, 0, 1, 8'h41);
    add(1, 8'h44, 1, 0, 1, 1, 8'h41);
    add(0, 8'h00, 1, 0, 1, 1, 8'h42);
    add(0, 8'h00, 1, 0, 1, 1, 8'h43);
    add(0, 8'h00, 1, 0, 1, 1, 8'h44);
    add(0, 8'h00, 1, 0, 1, 0, 8'h44);
    add(1, 8'h51, 0, 0, 1, 0, 8'h44);
    add(1, 8'h52, 0, 0, 1, 0, 8'h44);
    add(1, 8'h53, 0, 0, 1, 0, 8'h44);
    add(1, 8'h54, 1, 1, 0, 1, 8'h51);
    add(0, 8'h00, 1, 0, 1, 0, RV_MAIN);
    add(0, 8'h00, 1, 0, 1, 0, RV_MAIN);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_in_ready", i), ir3, vecs[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), ov3, vecs[i].e_ov);
      chk($sformatf("vec%0d_q", i), q3, vecs[i].e_q);
    end

    // asynchronous reset between edges with two words in flight
    drive(1, 8'h61, 0, 0);
    drive(1, 8'h62, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("pre_rst_ov", ov3, 1'b1);
    chk("pre_rst_q", q3, 8'h61);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_ov", ov3, 1'b0);
    chk("async_rst_q", q3, RV_MAIN);
    chk("async_rst_ir", ir3, 1'b1);
    chk("async_rst_q_small", q1, RV_SMALL);
    #1 reset = 1'b1;

    drive(1, 8'h71, 1, 0);
    chk("post_rst_empty0", ov3, 1'b0);
    for (int k = 1; k < 3; k++) begin
      drive(0, 8'h00, 1, 0);
      chk($sformatf("post_rst_empty%0d", k), ov3, 1'b0);
    end
    drive(0, 8'h00, 1, 0);
    chk("post_rst_ov", ov3, 1'b1);
    chk("post_rst_q", q3, 8'h71);
    repeat (4) drive(0, 8'h00, 1, 0);

    // random traffic against the scoreboards
    for (int n = 0; n < 1000; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      score();
    end
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      score();
    end
    chk("main_drained", sb3.size(), 0);
    chk("small_drained", sb1.size(), 0);

`ifdef DFF_PIPE_OCCUPANCY_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("occ_rst", occ4, 3'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
      chk($sformatf("occ_fill%0d", k), occ4, 3'(k));
    end
    drive(1'b1, 8'h90, 1'b1, 1'b0);
    chk("occ_full", occ4, 3'd4);
    chk("occ_full_ir", ir4, 1'b1);
    chk("occ_full_q", q4, 8'h80);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("occ_both", occ4, 3'd4);
    chk("occ_both_ov", ov4, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("occ_flush", occ4, 3'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
